// File: rtl/booth_multiplier.sv
// -----------------------------------------------------------------------------
// booth_multiplier
//
// Sequential radix-2 Booth multiplier. Produces the full 2*WIDTH-bit product of
// two WIDTH-bit operands, both treated as two's-complement (signed_i=1) or both
// as unsigned (signed_i=0). One Booth step is performed per clock cycle.
//
// Handshake: start_i is sampled only in IDLE. busy_o is high during the
// WIDTH+1 CALC cycles. done_o pulses for one cycle, and product_o carries the
// new result in that same cycle. product_o holds its value until the next
// completed operation or until reset. There is no queuing, so start_i outside
// IDLE is ignored.
//
// Ports:
//   clk_i           clock, rising edge
//   rst_ni          asynchronous active-low reset
//   start_i         request (sampled in IDLE only)
//   signed_i        1 = operands signed, 0 = unsigned (captured with start_i)
//   multiplicand_i  operand M (captured with start_i)
//   multiplier_i    operand Q (captured with start_i)
//   product_o       registered 2*WIDTH-bit result
//   busy_o          operation in progress (CALC state)
//   done_o          one-cycle completion pulse
//   state_o         current FSM state (0=IDLE, 1=CALC, 2=DONE)
// -----------------------------------------------------------------------------
module booth_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     multiplicand_i,
  input  logic [WIDTH-1:0]     multiplier_i,
  output logic [2*WIDTH-1:0]   product_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [1:0]           state_o
);

  localparam int unsigned CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH+1:0]     a_q, a_d;       // accumulator, one guard bit above M
  logic [WIDTH:0]       q_q, q_d;       // extended multiplier
  logic [WIDTH:0]       m_q, m_d;       // extended multiplicand
  logic                 qm1_q, qm1_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  logic [WIDTH+1:0]     m_ext;
  logic [WIDTH+1:0]     sum;
  logic [WIDTH+1:0]     a_sh;
  logic [WIDTH:0]       q_sh;
  logic                 last_step;

  // Booth step: add/subtract M according to {Q[0],Qm1}, then arithmetic
  // shift of {A,Q,Qm1} right by one. The A guard bit keeps -M from
  // overflowing when M is the most-negative value.
  always_comb begin
    m_ext = {m_q[WIDTH], m_q};
    sum   = a_q;
    case ({q_q[0], qm1_q})
      2'b01:   sum = a_q + m_ext;
      2'b10:   sum = a_q - m_ext;
      default: sum = a_q;
    endcase
    a_sh      = {sum[WIDTH+1], sum[WIDTH+1:1]};
    q_sh      = {sum[0], q_q[WIDTH:1]};
    last_step = (cnt_q == CW'(WIDTH));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          m_d     = signed_i ? {multiplicand_i[WIDTH-1], multiplicand_i}
                             : {1'b0, multiplicand_i};
          q_d     = signed_i ? {multiplier_i[WIDTH-1], multiplier_i}
                             : {1'b0, multiplier_i};
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        a_d   = a_sh;
        q_d   = q_sh;
        qm1_d = q_q[0];
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          // The product register is loaded together with the move into DONE
          // so that product_o is already new while done_o is high.
          prod_d  = {a_sh[WIDTH-2:0], q_sh};
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign product_o = prod_q;
  assign busy_o    = (state_q == S_CALC);
  assign done_o    = (state_q == S_DONE);
  assign state_o   = state_q;

endmodule

// File: doc/booth_multiplier.md
# booth_multiplier

Parametrised sequential radix-2 Booth multiplier. It computes the full 2·WIDTH-bit product of two WIDTH-bit operands, which may both be two's-complement or both unsigned, selected per operation. It succeeds the fixed 8-bit shift-add multiplier and its controller, and sits in the datapath as a multi-cycle arithmetic unit. Requests and results use a Start/Busy/Done handshake, and the result is held in a dedicated output register.

## Interface
Parameters:
- WIDTH, default 8, operand width in bits; legal values are 2..32.

Ports (name, direction, width, meaning):
- Clock  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  request; sampled only in IDLE.
- Signed  in  1  1 = both operands two's-complement, 0 = both unsigned; captured with Start.
- Multiplicand  in  WIDTH  operand M; captured with Start.
- Multiplier  in  WIDTH  operand Q; captured with Start.
- Product  out  2·WIDTH  registered result; holds the last completed product.
- Busy  out  1  high while an operation is in progress (CALC state).
- Done  out  1  one-cycle pulse; Product is valid and newly updated in the same cycle.

## Operation
- FSM states are IDLE, CALC and DONE; the reset state is IDLE.
- **IDLE**, when Start=1 at an edge:
  - Capture the operands, extended to WIDTH+1 bits: sign-extend if Signed=1, zero-extend if Signed=0.
  - Load registers: M ← extended multiplicand; Q ← extended multiplier; A ← 0 (WIDTH+2 bits); Qm1 ← 0; Count ← 0.
  - Go to CALC.
- **CALC**, once per cycle, based on {Q[0],Qm1}:
  - 01: A ← A + sign-extended M.
  - 10: A ← A − sign-extended M, computed as two's complement.
  - 00 or 11: A unchanged.
  - In the same cycle, the concatenation {A,Q,Qm1} is arithmetic-shifted right by 1, with A's MSB replicated. Count ← Count+1.
  - When Count reaches WIDTH (i.e. the (WIDTH+1)th iteration), go to DONE.
  - Count is $clog2(WIDTH+2) bits wide and never wraps within an operation.
- **DONE**:
  - Product ← bits [2·WIDTH−1:0] of the final {A,Q} register pair, with Q as the low part.
  - Done=1 for exactly this cycle; then go to IDLE.
- **Width rules**:
  - A is WIDTH+2 bits, so adding or subtracting the most-negative M cannot overflow.
  - The result is exact for every operand pair in both modes.
- **Start outside IDLE**: Start while in CALC or DONE is ignored, with no queuing. Operand input changes after capture have no effect.
- **Product stability**: Product changes only on the DONE-state update or on reset. It never shows intermediate values.
- **Reset**: asserting Reset at any time, including mid-CALC, forces IDLE asynchronously. It also clears Product=0, Done=0, Busy=0, A, Q, M, Qm1 and Count. An aborted operation produces no Done.
- **Back-to-back operation**: Start is accepted in the IDLE cycle immediately following Done.

## Timing
- If Start is sampled at edge k:
  - Busy=1 from edge k+1 through edge k+WIDTH+1 (WIDTH+1 CALC cycles).
  - Done=1 and the new Product are visible from edge k+WIDTH+2 for one cycle.
- Latency from Start to Done is WIDTH+2 cycles (10 for WIDTH=8).
- Minimum issue interval is WIDTH+3 cycles.
- Busy and Done are never high together.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Deassertion of Reset is assumed synchronised externally. The first Start is honoured at the first rising edge with Reset high.

## Test plan
- **Signed corner case (WIDTH=8, Signed=1)**: M=0x80, Q=0x80 → Product=0x4000 (16384). Done arrives exactly 10 cycles after Start. Busy is high for 9 cycles.
- **Unsigned maximum and mixed signs (WIDTH=8)**:
  - Signed=0, M=0xFF, Q=0xFF → Product=0xFE01 (65025).
  - Same operands with Signed=1 → Product=0x0001.
  - Signed=1, M=0x80, Q=0x7F → Product=0xC080 (−16256).
- **Ignored Start**: Start is re-pulsed with new operands (M=0x03, Q=0x05) during CALC and in the DONE cycle → both are ignored. The first result is unaffected, and no second Done occurs.
- **Reset mid-operation**: Reset is pulsed low 4 cycles into CALC → Busy=0, Done=0 and Product=0 immediately, with no Done afterwards. A new Start, Signed=1, M=0xFD (−3), Q=0x07 → Product=0xFFEB (−21).
- **Back-to-back**: Start is raised in the cycle after Done with M=0x0C, Q=0x0A → accepted, and Product=0x0078 appears WIDTH+2 cycles later. Product holds the previous value until then.
- **Random sweep (WIDTH=5, 8, 16)**: 10,000 random operand and mode triples per width → Product matches the golden model (M·Q, signed or unsigned) truncated to 2·WIDTH bits. Latency is always WIDTH+2 cycles. Coverage includes all four Booth digit pairs and operand values 0, 1, −1 and the most-negative value.
